// File: rtl/fiat_25519_pkg.sv
// Shared limb geometry, fold constant and FSM encoding for the 2^255-19 carry chain.
// Pure declarations: no latency, no backpressure.
package fiat_25519_pkg;

    localparam int NLIMBS      = 10;
    localparam int COL_WIDTH   = 64;
    localparam int LIMB_OUT    = 32;
    localparam int LIMB_W_EVEN = 26;
    localparam int LIMB_W_ODD  = 25;
    localparam int FOLD_K      = 19;
    localparam int CARRY_W     = 40;
    localparam int FOLD_W      = 46;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CARRY = 2'd1,
        S_FOLD  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/fiat_25519_carry_chain_if.sv
// Column-vector input and limb-vector output valid/ready bundle for the carry chain.
// Wiring only: no latency; the slave holds ready low while busy.
interface fiat_25519_carry_chain_if;
    import fiat_25519_pkg::*;

    logic                          in_valid;
    logic                          in_ready;
    logic [NLIMBS*COL_WIDTH-1:0]   in_cols;
    logic                          out_valid;
    logic                          out_ready;
    logic [NLIMBS*LIMB_OUT-1:0]    out_limbs;

    modport master (
        output in_valid, in_cols, out_ready,
        input  in_ready, out_valid, out_limbs
    );

    modport slave (
        input  in_valid, in_cols, out_ready,
        output in_ready, out_valid, out_limbs
    );

endinterface

// File: rtl/fiat_25519_mul19.sv
// Combinational x19 of a 40-bit carry using shift-adds, for folding 2^255 back into limb 0.
// Zero latency, no handshake.
module fiat_25519_mul19 (
    input  logic [39:0] c,
    output logic [44:0] p
);

    // 19*c = 16c + 2c + c; every term is widened so the sum cannot wrap.
    assign p = {1'b0, c, 4'b0000} + {4'b0000, c, 1'b0} + {5'b00000, c};

endmodule

// File: rtl/fiat_25519_carry_chain.sv
// Radix-2^25.5 carry propagation (one limb per cycle) with x19 top-carry fold; output 11 edges
// after accept. Single vector in flight: in_ready low while busy, limbs held until out_ready.
module fiat_25519_carry_chain
    import fiat_25519_pkg::*;
(
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    fiat_25519_carry_chain_if.slave   bus
);

    state_t               state_q;
    state_t               state_d;
    logic                 accept;

    logic [3:0]           idx_q;
    logic [CARRY_W-1:0]   carry_q;
    logic [COL_WIDTH-1:0] col_q  [NLIMBS];
    logic [25:0]          limb_q [NLIMBS];

    logic [COL_WIDTH:0]   t_sum;
    logic [25:0]          limb_new;
    logic [CARRY_W-1:0]   carry_new;
    logic [44:0]          fold_prod;
    logic [FOLD_W-1:0]    fold_sum;
    logic [25:0]          limb1_fold;

    // Carry step: odd limbs keep 25 bits, even limbs 26; the carry register holds the full 65-W bits.
    always_comb begin
        t_sum = {1'b0, col_q[idx_q]} + {{(COL_WIDTH+1-CARRY_W){1'b0}}, carry_q};
        if (idx_q[0]) begin
            limb_new  = {1'b0, t_sum[LIMB_W_ODD-1:0]};
            carry_new = t_sum[COL_WIDTH:LIMB_W_ODD];
        end else begin
            limb_new  = t_sum[LIMB_W_EVEN-1:0];
            carry_new = {1'b0, t_sum[COL_WIDTH:LIMB_W_EVEN]};
        end
    end

    fiat_25519_mul19 u_mul19 (
        .c (carry_q),
        .p (fold_prod)
    );

    assign fold_sum   = {20'd0, limb_q[0]} + {1'b0, fold_prod};
    assign limb1_fold = limb_q[1] + 26'(fold_sum[FOLD_W-1:LIMB_W_EVEN]);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.in_ready = ap_rst_n;
                accept       = bus.in_valid && ap_rst_n;
                if (accept) begin
                    state_d = S_CARRY;
                end
            end
            S_CARRY: begin
                if (idx_q == 4'(NLIMBS - 1)) begin
                    state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            idx_q   <= 4'd0;
            carry_q <= '0;
            for (int i = 0; i < NLIMBS; i++) begin
                limb_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        idx_q   <= 4'd0;
                        carry_q <= '0;
                        for (int i = 0; i < NLIMBS; i++) begin
                            col_q[i] <= bus.in_cols[COL_WIDTH*i +: COL_WIDTH];
                        end
                    end
                end
                S_CARRY: begin
                    limb_q[idx_q] <= limb_new;
                    carry_q       <= carry_new;
                    idx_q         <= idx_q + 4'd1;
                end
                S_FOLD: begin
                    limb_q[0] <= fold_sum[LIMB_W_EVEN-1:0];
                    limb_q[1] <= limb1_fold;
                end
                default: begin
                end
            endcase
        end
    end

    // Limb registers are only written outside S_OUT, so the output is stable under backpressure.
    always_comb begin
        bus.out_limbs = '0;
        for (int i = 0; i < NLIMBS; i++) begin
            bus.out_limbs[LIMB_OUT*i +: LIMB_OUT] = {{(LIMB_OUT-26){1'b0}}, limb_q[i]};
        end
    end

endmodule

// File: tb/tb_fiat_25519_carry_chain.sv
// Scoreboard bench for the carry chain: directed corner vectors plus random traffic with gaps.
module tb_fiat_25519_carry_chain;

    logic ap_clk;
    logic ap_rst_n;
    int   checks;
    int   errors;
    bit   rand_rdy;
    logic [319:0] exp_q[$];
    logic [319:0] last_out;

    fiat_25519_carry_chain_if bus ();

    fiat_25519_carry_chain dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    function automatic logic [319:0] model(input logic [639:0] cols);
        logic [127:0] acc;
        logic [127:0] carry;
        logic [127:0] lim [10];
        logic [319:0] r;
        int w;
        carry = '0;
        for (int i = 0; i < 10; i++) begin
            w      = (i % 2 == 0) ? 26 : 25;
            acc    = 128'(cols[64*i +: 64]) + carry;
            lim[i] = acc & ((128'd1 << w) - 128'd1);
            carry  = acc >> w;
        end
        acc    = lim[0] + 128'd19 * carry;
        lim[0] = acc & 128'h3ffffff;
        lim[1] = lim[1] + (acc >> 26);
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[32*i +: 32] = lim[i][31:0];
        end
        return r;
    endfunction

    always @(negedge ap_clk) begin
        if (ap_rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected got=%h", bus.out_limbs);
            end else begin
                logic [319:0] e;
                e = exp_q.pop_front();
                last_out = bus.out_limbs;
                if (bus.out_limbs !== e) begin
                    errors++;
                    $display("FAIL scoreboard_limbs got=%h exp=%h", bus.out_limbs, e);
                end
            end
        end
    end

    always @(posedge ap_clk) begin
        if (rand_rdy) begin
            #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [639:0] cols, input bit push, input logic [319:0] exp);
        bit ok;
        ok = 1'b0;
        bus.in_cols  = cols;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge ap_clk);
            if (bus.in_ready) begin
                if (push) exp_q.push_back(exp);
                @(posedge ap_clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready never seen high");
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) begin
            @(posedge ap_clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        ap_rst_n      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_cols   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.out_limbs !== 320'd0) begin
            errors++; $display("FAIL reset_out_limbs got=%h exp=0", bus.out_limbs);
        end
        ap_rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready);
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_zero_latency();
        int lat;
        lat = 0;
        send('0, 1'b1, 320'd0);
        for (int n = 1; n <= 25; n++) begin
            @(posedge ap_clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat != 11) begin
            errors++; $display("FAIL latency got=%0d exp=11", lat);
        end
        wait_drain();
    endtask

    task automatic test_single_carry();
        logic [639:0] c;
        logic [319:0] e;
        c = '0;
        c[63:0] = 64'h4000000;
        e = '0;
        e[63:32] = 32'd1;
        send(c, 1'b1, e);
        wait_drain();
    endtask

    task automatic test_fold();
        logic [639:0] c;
        logic [319:0] e;
        c = '0;
        c[639:576] = 64'h2000000;
        e = '0;
        e[31:0] = 32'd19;
        send(c, 1'b1, e);
        wait_drain();
    endtask

    task automatic test_all_ones();
        logic [639:0] c;
        c = '1;
        send(c, 1'b1, model(c));
        wait_drain();
        checks++;
        if (last_out[63:58] !== 6'd0) begin
            errors++; $display("FAIL all_ones_limb1_bound got=%h exp_below=4000000", last_out[63:32]);
        end
    endtask

    task automatic test_backpressure();
        logic [639:0] c;
        logic [319:0] held;
        bit seen;
        c = {10{64'h0123_4567_89ab_cdef}};
        bus.out_ready = 1'b0;
        seen = 1'b0;
        send(c, 1'b1, model(c));
        for (int n = 0; n < 30; n++) begin
            @(posedge ap_clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL bp_out_valid_timeout got=0 exp=1");
        end
        held = bus.out_limbs;
        for (int k = 0; k < 5; k++) begin
            @(posedge ap_clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_limbs !== held) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d valid=%b ready=%b limbs=%h exp_limbs=%h",
                         k, bus.out_valid, bus.in_ready, bus.out_limbs, held);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_valid_drop got=%b exp=0", bus.out_valid);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        logic [639:0] c;
        c = {10{64'hdead_beef_cafe_f00d}};
        send(c, 1'b0, '0);
        repeat (4) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state in_ready=%b out_valid=%b exp=1/0", bus.in_ready, bus.out_valid);
        end
        c = {10{64'h0000_0fff_ffff_ffff}};
        send(c, 1'b1, model(c));
        wait_drain();
    endtask

    task automatic test_random();
        logic [639:0] c;
        rand_rdy = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            for (int i = 0; i < 10; i++) begin
                case ($urandom_range(0, 3))
                    0: c[64*i +: 64] = '1;
                    1: c[64*i +: 64] = 64'($urandom);
                    default: c[64*i +: 64] = {$urandom, $urandom};
                endcase
            end
            repeat ($urandom_range(0, 3)) @(posedge ap_clk);
            #1;
            send(c, 1'b1, model(c));
        end
        wait_drain();
        rand_rdy = 1'b0;
        @(posedge ap_clk);
        #2;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rand_rdy = 1'b0;
        last_out = '0;
        test_reset();
        test_zero_latency();
        test_single_carry();
        test_fold();
        test_all_ones();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
